sha3_sponge_ctrl: RTL

// - SHA3-256 sponge controller that sits directly upstream of perm_stage: absorbs message lanes,

---
 rtl/sha3_sponge_ctrl_pkg.sv | 50 +++++
 rtl/sha3_sponge_ctrl_if.sv | 35 +++
 rtl/sha3_sponge_ctrl_pad_gen.sv | 25 ++
 rtl/sha3_sponge_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sha3_sponge_ctrl_pkg.sv
// SHA3-256 sponge controller: shared types, constants and lane helpers.
// Contents: state_t (5x5x64, [x][y]), rate_t, fsm_e, lane_x/lane_y, byte_mask.
package sha3_sponge_ctrl_pkg;

  localparam int Z_AXIS     = 64;
  localparam int RATE_LANES = 17;
  localparam int OUT_LANES  = 4;
  localparam int NUM_STAGES = 8;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef logic [Z_AXIS-1:0] lane_t;

  // indexed s[x][y]
  typedef logic [4:0][4:0][Z_AXIS-1:0] state_t;

  typedef logic [RATE_LANES-1:0][Z_AXIS-1:0] rate_t;

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    PERM,
    DONE
  } fsm_e;

  function automatic logic [2:0] lane_x(logic [4:0] i);
    return 3'(i % 5'd5);
  endfunction

  function automatic logic [2:0] lane_y(logic [4:0] i);
    return 3'(i / 5'd5);
  endfunction

  // Keeps the low n bytes of a lane.
  function automatic lane_t byte_mask(logic [3:0] n);
    lane_t m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < n)
        m[8*b +: 8] = 8'hff;
    end
    return m;
  endfunction

  function automatic logic [3:0] clamp_bytes(logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/sha3_sponge_ctrl_if.sv
// Handshake bundle between the sponge controller and its neighbours.
// Message in, perm_stage drive/return, digest out. master = controller.
interface sha3_sponge_ctrl_if;
  import sha3_sponge_ctrl_pkg::*;

  logic        in_valid;
  logic        in_ready;
  lane_t       in_data;
  logic        in_last;
  logic [3:0]  in_bytes;

  logic        st_en;
  logic [31:0] st_idx;
  state_t      st_in;
  state_t      st_out;

  logic        out_valid;
  logic        out_ready;
  logic [255:0] digest;

  modport master (
    input  in_valid, in_data, in_last, in_bytes,
    input  st_out, out_ready,
    output in_ready, st_en, st_idx, st_in,
    output out_valid, digest
  );

  modport slave (
    output in_valid, in_data, in_last, in_bytes,
    output st_out, out_ready,
    input  in_ready, st_en, st_idx, st_in,
    input  out_valid, digest
  );

endinterface

// File: rtl/sha3_sponge_ctrl_pad_gen.sv
// Combinational pad10*1 generator for the 17-lane SHA3-256 rate.
// In: pad_lane (0..16), pad_byte (0..7). Out: pad, XORed into rate.
module sha3_pad_gen
  import sha3_sponge_ctrl_pkg::*;
(
  input  logic [4:0] pad_lane,
  input  logic [2:0] pad_byte,
  output rate_t      pad
);

  always_comb begin
    pad = '0;
    for (int i = 0; i < RATE_LANES; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (5'(i) == pad_lane &&
            3'(b) == pad_byte)
          pad[i][8*b +: 8] = PAD_DOMAIN;
      end
    end
    // XOR so a shared last byte becomes 0x86
    pad[RATE_LANES-1][63:56] =
      pad[RATE_LANES-1][63:56] ^ PAD_FINAL;
  end

endmodule

// File: rtl/sha3_sponge_ctrl.sv
// SHA3-256 sponge controller: absorb, pad, drive perm_stage 8x, emit digest.
// Ports: clk, reset (async, active-high), bus (sha3_sponge_ctrl_if.master).
// Optional SHA3_PERM_CNT_EN: adds perm_count[31:0] (completed permutations).
module sha3_sponge_ctrl
  import sha3_sponge_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  sha3_sponge_ctrl_if.master bus
`ifdef SHA3_PERM_CNT_EN
  ,
  output logic [31:0] perm_count
`endif
);

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES-1);
  localparam logic [3:0] CYC_LAST  = 4'(NUM_STAGES);
  localparam logic [3:0] CYC_STG7  = 4'(NUM_STAGES-1);

  fsm_e       fsm;
  state_t     s;
  logic [4:0] lane_cnt;
  logic [3:0] cyc;
  logic [2:0] idx;
  logic       fin;
  logic       pad_pend;
  logic [4:0] pad_lane;
  logic [2:0] pad_byte;
  rate_t      pad;
  logic [3:0] nbytes;
  lane_t      lane_in;
  logic       xfer;

  sha3_pad_gen u_pad (
    .pad_lane (pad_lane),
    .pad_byte (pad_byte),
    .pad      (pad)
  );

  assign xfer    = bus.in_valid & bus.in_ready;
  assign nbytes  = bus.in_last
                 ? clamp_bytes(bus.in_bytes)
                 : 4'd8;
  assign lane_in = bus.in_data & byte_mask(nbytes);

  assign bus.st_idx = {29'd0, idx};

  // cycle 0 feeds the held state, later cycles chain perm_stage output
  assign bus.st_in = (fsm == PERM && cyc != 4'd0)
                   ? bus.st_out
                   : s;

  always_comb begin
    bus.digest = '0;
    if (bus.out_valid) begin
      for (int k = 0; k < OUT_LANES; k++)
        bus.digest[64*k +: 64] = s[k][0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm           <= ABSORB;
      s             <= '0;
      lane_cnt      <= '0;
      cyc           <= '0;
      idx           <= '0;
      fin           <= 1'b0;
      pad_pend      <= 1'b0;
      pad_lane      <= '0;
      pad_byte      <= '0;
      bus.in_ready  <= 1'b1;
      bus.st_en     <= 1'b0;
      bus.out_valid <= 1'b0;
`ifdef SHA3_PERM_CNT_EN
      perm_count    <= '0;
`endif
    end else begin
      unique case (fsm)
        ABSORB: begin
          if (xfer) begin
            s[lane_x(lane_cnt)][lane_y(lane_cnt)] <=
              s[lane_x(lane_cnt)][lane_y(lane_cnt)] ^ lane_in;
            lane_cnt <= lane_cnt + 5'd1;
            if (!bus.in_last) begin
              if (lane_cnt == LAST_LANE) begin
                fin          <= 1'b0;
                pad_pend     <= 1'b0;
                fsm          <= PERM;
                cyc          <= '0;
                idx          <= '0;
                bus.st_en    <= 1'b1;
                bus.in_ready <= 1'b0;
              end
            end else if (nbytes != 4'd8) begin
              pad_lane     <= lane_cnt;
              pad_byte     <= nbytes[2:0];
              fsm          <= PAD;
              bus.in_ready <= 1'b0;
            end else if (lane_cnt == LAST_LANE) begin
              // full last block: permute, then a pad-only block
              pad_lane     <= '0;
              pad_byte     <= '0;
              pad_pend     <= 1'b1;
              fin          <= 1'b0;
              fsm          <= PERM;
              cyc          <= '0;
              idx          <= '0;
              bus.st_en    <= 1'b1;
              bus.in_ready <= 1'b0;
            end else begin
              pad_lane     <= lane_cnt + 5'd1;
              pad_byte     <= '0;
              fsm          <= PAD;
              bus.in_ready <= 1'b0;
            end
          end
        end

        PAD: begin
          for (int i = 0; i < RATE_LANES; i++)
            s[i%5][i/5] <= s[i%5][i/5] ^ pad[i];
          fin       <= 1'b1;
          pad_pend  <= 1'b0;
          fsm       <= PERM;
          cyc       <= '0;
          idx       <= '0;
          bus.st_en <= 1'b1;
        end

        PERM: begin
          if (cyc == CYC_LAST) begin
            s        <= bus.st_out;
            lane_cnt <= '0;
            cyc      <= '0;
`ifdef SHA3_PERM_CNT_EN
            perm_count <= perm_count + 32'd1;
`endif
            if (fin) begin
              fsm           <= DONE;
              bus.out_valid <= 1'b1;
            end else if (pad_pend) begin
              fsm <= PAD;
            end else begin
              fsm          <= ABSORB;
              bus.in_ready <= 1'b1;
            end
          end else begin
            cyc <= cyc + 4'd1;
            if (cyc == CYC_STG7) begin
              bus.st_en <= 1'b0;
              idx       <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            s             <= '0;
            bus.out_valid <= 1'b0;
            fsm           <= ABSORB;
            bus.in_ready  <= 1'b1;
          end
        end

        default: begin
          fsm <= ABSORB;
        end
      endcase
    end
  end

endmodule
